// File: rtl/nv_nvdla_sdp_hls_y_lut_rd_pkg.sv
// Shared definitions for the SDP Y-LUT read stage: per-lane field offsets,
// table limits, per-lane records and the second-address helper.
package nv_nvdla_sdp_hls_y_lut_rd_pkg;

    // Field widths within one lane
    localparam int FRAC_W = 35;
    localparam int X_W    = 32;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    // Input beat: every field is grouped across lanes; the base of a field
    // group is (offset * K), and lane i sits at base + width * i.
    localparam int IN_LANE_W      = 81;
    localparam int IN_FRAC_BASE   = 0;
    localparam int IN_X_BASE      = 35;
    localparam int IN_OFLOW_BASE  = 67;
    localparam int IN_UFLOW_BASE  = 68;
    localparam int IN_SEL_BASE    = 69;
    localparam int IN_ADDR_BASE   = 70;
    localparam int IN_LE_HIT_BASE = 79;
    localparam int IN_LO_HIT_BASE = 80;

    // Output beat, same grouping scheme
    localparam int OUT_LANE_W      = 104;
    localparam int OUT_Y0_BASE     = 0;
    localparam int OUT_Y1_BASE     = 16;
    localparam int OUT_FRAC_BASE   = 32;
    localparam int OUT_X_BASE      = 67;
    localparam int OUT_OFLOW_BASE  = 99;
    localparam int OUT_UFLOW_BASE  = 100;
    localparam int OUT_SEL_BASE    = 101;
    localparam int OUT_LE_HIT_BASE = 102;
    localparam int OUT_LO_HIT_BASE = 103;

    // Last valid entry of each table
    localparam logic [ADDR_W-1:0] LE_LAST = 9'd64;
    localparam logic [ADDR_W-1:0] LO_LAST = 9'd256;

    // One lane of an incoming index beat
    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        logic [X_W-1:0]    x;
        logic              oflow;
        logic              uflow;
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic              le_hit;
        logic              lo_hit;
    } lut_in_lane_t;

    // Sideband carried alongside the RAM read until the data returns
    typedef struct packed {
        logic [FRAC_W-1:0] frac;
        logic [X_W-1:0]    x;
        logic              oflow;
        logic              uflow;
        logic              sel;
        logic              le_hit;
        logic              lo_hit;
    } lut_side_t;

    // Address of the upper interpolation point: addr+1 clamped to the
    // selected table's last entry; out-of-range lanes reuse addr.
    function automatic logic [ADDR_W-1:0] calc_addr1(
        input logic [ADDR_W-1:0] addr,
        input logic              sel,
        input logic              flow
    );
        logic [ADDR_W-1:0] last;
        last = sel ? LO_LAST : LE_LAST;
        if (flow) begin
            return addr;
        end else if (addr >= last) begin
            return last;
        end else begin
            return addr + ADDR_W'(1);
        end
    endfunction

endpackage

// File: rtl/nv_nvdla_sdp_hls_y_lut_rd_fifo.sv
// Return buffer: DEPTH-entry synchronous FIFO with a first-word-fall-through
// head and an occupancy count. The producer guarantees it never overflows.
module nv_nvdla_sdp_hls_y_lut_rd_fifo
    import nv_nvdla_sdp_hls_y_lut_rd_pkg::*;
#(
    parameter int WIDTH = 104,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths also work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (count_q == '0);
    assign pop_ok = pop & ~empty;
    assign count  = count_q;
    assign rdata  = mem[rd_ptr_q];

    // Next pointer/occupancy; simultaneous push and pop cancel in the count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
    end

    // Control state register
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are qualified by count so need no reset
    always_ff @(posedge nvdla_core_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/nv_nvdla_sdp_hls_y_lut_rd.sv
// SDP Y-LUT read stage: issues LE/LO table reads for each accepted index
// beat, carries the sideband alongside the read, and joins both into a
// return FIFO that presents results in acceptance order.
module nv_nvdla_sdp_hls_y_lut_rd
    import nv_nvdla_sdp_hls_y_lut_rd_pkg::*;
#(
    parameter int K     = 1,
    parameter int DEPTH = 4
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic                    chn_lut_in_pvld,
    output logic                    chn_lut_in_prdy,
    input  logic [IN_LANE_W*K-1:0]  chn_lut_in_pd,
    output logic                    lut_rd_en,
    output logic [K-1:0]            lut_rd_sel,
    output logic [ADDR_W*K-1:0]     lut_rd_addr0,
    output logic [ADDR_W*K-1:0]     lut_rd_addr1,
    input  logic [DATA_W*K-1:0]     lut_rd_data0,
    input  logic [DATA_W*K-1:0]     lut_rd_data1,
    output logic                    chn_lut_out_pvld,
    input  logic                    chn_lut_out_prdy,
    output logic [OUT_LANE_W*K-1:0] chn_lut_out_pd
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                    inflight_q, inflight_d;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [CNT_W:0]          occupancy;
    logic [OUT_LANE_W*K-1:0] fifo_wdata;

    // Space is reserved at issue time for every outstanding read, so the
    // ready decision depends only on registered state.
    assign occupancy       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign chn_lut_in_prdy = ~nvdla_core_rst & (occupancy < (CNT_W + 1)'(DEPTH));
    assign lut_rd_en       = chn_lut_in_pvld & chn_lut_in_prdy;

    // A read issued this cycle returns its data next cycle
    always_comb begin
        inflight_d = lut_rd_en;
    end

    // Outstanding-read flag; reset drops any read whose data is still due
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_lane
            lut_in_lane_t      lane_in;
            lut_side_t         side_d;
            lut_side_t         side_q;
            logic [DATA_W-1:0] y0;
            logic [DATA_W-1:0] y1;

            // Extract this lane's fields and the sideband to be carried
            always_comb begin
                lane_in        = '0;
                lane_in.frac   = chn_lut_in_pd[IN_FRAC_BASE*K + FRAC_W*gi +: FRAC_W];
                lane_in.x      = chn_lut_in_pd[IN_X_BASE*K + X_W*gi +: X_W];
                lane_in.oflow  = chn_lut_in_pd[IN_OFLOW_BASE*K + gi];
                lane_in.uflow  = chn_lut_in_pd[IN_UFLOW_BASE*K + gi];
                lane_in.sel    = chn_lut_in_pd[IN_SEL_BASE*K + gi];
                lane_in.addr   = chn_lut_in_pd[IN_ADDR_BASE*K + ADDR_W*gi +: ADDR_W];
                lane_in.le_hit = chn_lut_in_pd[IN_LE_HIT_BASE*K + gi];
                lane_in.lo_hit = chn_lut_in_pd[IN_LO_HIT_BASE*K + gi];

                side_d        = '0;
                side_d.frac   = lane_in.frac;
                side_d.x      = lane_in.x;
                side_d.oflow  = lane_in.oflow;
                side_d.uflow  = lane_in.uflow;
                side_d.sel    = lane_in.sel;
                side_d.le_hit = lane_in.le_hit;
                side_d.lo_hit = lane_in.lo_hit;
            end

            // RAM address/select; held at zero while in reset
            assign lut_rd_sel[gi] = ~nvdla_core_rst & lane_in.sel;
            assign lut_rd_addr0[ADDR_W*gi +: ADDR_W] =
                nvdla_core_rst ? '0 : lane_in.addr;
            assign lut_rd_addr1[ADDR_W*gi +: ADDR_W] =
                nvdla_core_rst ? '0 :
                calc_addr1(lane_in.addr, lane_in.sel, lane_in.oflow | lane_in.uflow);

            // Sideband delay matching the one-cycle RAM read latency
            always_ff @(posedge nvdla_core_clk) begin
                side_q <= side_d;
            end

            // Out-of-range lanes have a single valid point, so y1 mirrors y0
            always_comb begin
                y0 = lut_rd_data0[DATA_W*gi +: DATA_W];
                y1 = (side_q.oflow | side_q.uflow) ? y0 : lut_rd_data1[DATA_W*gi +: DATA_W];
            end

            assign fifo_wdata[OUT_Y0_BASE*K + DATA_W*gi +: DATA_W]  = y0;
            assign fifo_wdata[OUT_Y1_BASE*K + DATA_W*gi +: DATA_W]  = y1;
            assign fifo_wdata[OUT_FRAC_BASE*K + FRAC_W*gi +: FRAC_W] = side_q.frac;
            assign fifo_wdata[OUT_X_BASE*K + X_W*gi +: X_W]         = side_q.x;
            assign fifo_wdata[OUT_OFLOW_BASE*K + gi]                = side_q.oflow;
            assign fifo_wdata[OUT_UFLOW_BASE*K + gi]                = side_q.uflow;
            assign fifo_wdata[OUT_SEL_BASE*K + gi]                  = side_q.sel;
            assign fifo_wdata[OUT_LE_HIT_BASE*K + gi]               = side_q.le_hit;
            assign fifo_wdata[OUT_LO_HIT_BASE*K + gi]               = side_q.lo_hit;
        end
    endgenerate

    assign chn_lut_out_pvld = ~fifo_empty;

    nv_nvdla_sdp_hls_y_lut_rd_fifo #(
        .WIDTH (OUT_LANE_W * K),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .push           (inflight_q),
        .wdata          (fifo_wdata),
        .pop            (chn_lut_out_prdy),
        .rdata          (chn_lut_out_pd),
        .empty          (fifo_empty),
        .count          (fifo_count)
    );

endmodule

// File: tb/tb_nv_nvdla_sdp_hls_y_lut_rd.sv
// Randomized bench for the Y-LUT read stage with a transaction-level model:
// a RAM model answering reads, and a scoreboard of expected result beats.
module tb_nv_nvdla_sdp_hls_y_lut_rd;

    localparam int K     = 1;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_pvld = 1'b0;
    logic         in_prdy;
    logic [80:0]  in_pd = '0;
    logic         rd_en;
    logic [0:0]   rd_sel;
    logic [8:0]   addr0, addr1;
    logic [15:0]  data0 = '0, data1 = '0;
    logic         out_pvld;
    logic         out_prdy = 1'b0;
    logic [103:0] out_pd;

    typedef struct {
        logic [34:0] frac;
        logic [31:0] x;
        logic        of, uf, sel;
        logic [8:0]  addr;
        logic        le, lo;
    } beat_t;

    typedef struct {
        logic [103:0] pd;
        int           cyc;
    } exp_t;

    exp_t        sb[$];
    beat_t       cur;
    logic [15:0] tbl [2][512];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pop = 0;

    nv_nvdla_sdp_hls_y_lut_rd #(.K(K), .DEPTH(DEPTH)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rst   (rst),
        .chn_lut_in_pvld  (in_pvld),
        .chn_lut_in_prdy  (in_prdy),
        .chn_lut_in_pd    (in_pd),
        .lut_rd_en        (rd_en),
        .lut_rd_sel       (rd_sel),
        .lut_rd_addr0     (addr0),
        .lut_rd_addr1     (addr1),
        .lut_rd_data0     (data0),
        .lut_rd_data1     (data1),
        .chn_lut_out_pvld (out_pvld),
        .chn_lut_out_prdy (out_prdy),
        .chn_lut_out_pd   (out_pd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [80:0] pack_in(input beat_t b);
        return {b.lo, b.le, b.addr, b.sel, b.uf, b.of, b.x, b.frac};
    endfunction

    // addr+1 limited to the last table entry; flagged lanes keep addr
    function automatic int exp_a1(input beat_t b);
        int last;
        last = b.sel ? 256 : 64;
        if (b.of || b.uf) return int'(b.addr);
        return (int'(b.addr) + 1 > last) ? last : int'(b.addr) + 1;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        int    last;
        b.sel = 1'($urandom_range(0, 1));
        last  = b.sel ? 256 : 64;
        case ($urandom_range(0, 5))
            0:       b.addr = 9'd0;
            1:       b.addr = 9'(last - 1);
            2:       b.addr = 9'(last);
            3:       b.addr = 9'($urandom_range(0, 511));
            default: b.addr = 9'($urandom_range(0, last));
        endcase
        b.of   = ($urandom_range(0, 7) == 0);
        b.uf   = ($urandom_range(0, 7) == 0);
        b.frac = 35'({$urandom(), $urandom()});
        b.x    = $urandom();
        b.le   = 1'($urandom_range(0, 1));
        b.lo   = 1'($urandom_range(0, 1));
        return b;
    endfunction

    function automatic beat_t mk_beat(input int addr, input bit sel, input bit of);
        beat_t b;
        b      = rand_beat();
        b.addr = 9'(addr);
        b.sel  = sel;
        b.of   = of;
        b.uf   = 1'b0;
        return b;
    endfunction

    task automatic set_beat(input beat_t b);
        cur   = b;
        in_pd = pack_in(b);
    endtask

    // RAM: data valid one cycle after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (rd_en) begin
            data0 <= tbl[rd_sel][addr0];
            data1 <= tbl[rd_sel][addr1];
        end else begin
            data0 <= 16'($urandom());
            data1 <= 16'($urandom());
        end
    end

    always @(posedge clk) cyc++;

    // Monitor: compares handshakes and result beats with the model
    always @(negedge clk) begin
        bit           exp_rdy, exp_vld;
        logic [15:0]  y0, y1;
        int           a1;
        exp_t         e;
        if (rst) begin
            chk("rst_in_prdy", in_prdy, 0);
            chk("rst_out_pvld", out_pvld, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_rd_addr", {rd_sel, addr0, addr1}, 0);
            sb.delete();
        end else begin
            exp_rdy = (sb.size() < DEPTH);
            exp_vld = (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
            chk("in_prdy", in_prdy, exp_rdy);
            chk("out_pvld", out_pvld, exp_vld);
            chk("rd_en", rd_en, in_pvld & exp_rdy);
            if (out_pvld && out_prdy && sb.size() > 0) begin
                chk("out_pd", out_pd, sb[0].pd);
                $display("pop  cyc=%0d pd=%h", cyc, out_pd);
                void'(sb.pop_front());
                n_pop++;
            end
            if (in_pvld && in_prdy) begin
                a1 = exp_a1(cur);
                chk("rd_addr0", addr0, cur.addr);
                chk("rd_addr1", addr1, a1);
                chk("rd_sel", rd_sel, cur.sel);
                y0 = tbl[cur.sel][cur.addr];
                y1 = (cur.of || cur.uf) ? y0 : tbl[cur.sel][9'(a1)];
                e.pd  = {cur.lo, cur.le, cur.sel, cur.uf, cur.of, cur.x, cur.frac, y1, y0};
                e.cyc = cyc;
                sb.push_back(e);
                $display("push cyc=%0d sel=%0d addr=%0d of=%0d uf=%0d", cyc, cur.sel, cur.addr, cur.of, cur.uf);
            end
        end
    end

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_pvld && in_prdy && !rst;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input beat_t b, input int maxc);
        bit acc;
        set_beat(b);
        in_pvld = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < maxc && !acc; i++) tick(acc);
        if (!acc) chk("send_timeout", 0, 1);
        in_pvld = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        in_pvld  = 1'b0;
        out_prdy = 1'b1;
        for (int i = 0; i < 200 && sb.size() > 0; i++) tick(acc);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Waits for out_pvld after an accept; returns cycles since acceptance
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_pvld && lat < 10) begin
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        bit    acc;
        int    lat, sent, pops0, misses;
        beat_t b;
        int    cl_addr [4] = '{64, 256, 63, 256};
        bit    cl_sel  [4] = '{0, 1, 0, 1};
        bit    cl_of   [4] = '{0, 0, 0, 1};
        int    cl_exp  [4] = '{64, 256, 64, 256};

        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 512; a++) tbl[s][a] = 16'($urandom());
        tbl[0][5] = 16'h1234;
        tbl[0][6] = 16'h1235;

        // Reset held for a few cycles, then released
        repeat (3) tick(acc);
        rst = 1'b0;

        // Single beat and its latency
        out_prdy = 1'b1;
        b = mk_beat(5, 0, 0);
        send(b, 10);
        wait_out(lat);
        chk("single_lat", lat, 2);
        chk("single_y0", out_pd[15:0], 16'h1234);
        chk("single_y1", out_pd[31:16], 16'h1235);
        chk("single_frac", out_pd[66:32], b.frac);
        chk("single_x", out_pd[98:67], b.x);
        @(posedge clk); #1;
        drain();

        // Clamp and overflow addresses, expected values written out
        for (int i = 0; i < 4; i++) begin
            b = mk_beat(cl_addr[i], cl_sel[i], cl_of[i]);
            set_beat(b);
            #1;
            chk($sformatf("clamp%0d_addr1", i), addr1, cl_exp[i]);
            send(b, 10);
        end
        drain();

        // Backpressure: six beats offered with the output stalled
        out_prdy = 1'b0;
        sent = 0;
        set_beat(rand_beat());
        in_pvld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(acc);
            if (acc) begin
                sent++;
                if (sent < 6) set_beat(rand_beat()); else in_pvld = 1'b0;
            end
        end
        chk("bp_accepted", sent, 4);
        @(negedge clk);
        chk("bp_in_prdy", in_prdy, 0);
        @(posedge clk); #1;
        pops0 = n_pop;
        out_prdy = 1'b1;
        for (int i = 0; i < 60 && (sent < 6 || sb.size() > 0); i++) begin
            tick(acc);
            if (acc) begin
                sent++;
                if (sent < 6) set_beat(rand_beat()); else in_pvld = 1'b0;
            end
        end
        in_pvld = 1'b0;
        chk("bp_out_count", n_pop - pops0, 6);
        drain();

        // Streaming at one beat per cycle
        out_prdy = 1'b1;
        sent = 0;
        misses = 0;
        set_beat(rand_beat());
        in_pvld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick(acc);
            if (acc) begin
                sent++;
                set_beat(rand_beat());
            end else begin
                misses++;
            end
        end
        in_pvld = 1'b0;
        chk("stream_accepts", sent, 100);
        chk("stream_stalls", misses, 0);
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            out_prdy = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc || !in_pvld) begin
                in_pvld = ($urandom_range(0, 2) != 0);
                set_beat(rand_beat());
            end
        end
        drain();

        // Reset with beats buffered and a read still outstanding
        out_prdy = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_beat(), 10);
        rst = 1'b1;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        out_prdy = 1'b1;
        send(rand_beat(), 10);
        wait_out(lat);
        chk("rst_post_lat", lat, 2);
        @(negedge clk);
        chk("rst_post_alone", out_pvld, 0);
        @(posedge clk); #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/nv_nvdla_sdp_hls_y_lut_rd.md
NV_NVDLA_SDP_HLS_Y_LUT_RD -- requirements
Module: nv_nvdla_sdp_hls_y_lut_rd

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: nvdla_core_clk, nvdla_core_rst.
REQ-002 Parameter K, default 1: lanes per beat. Parameter DEPTH, default 4: return-FIFO entries.
REQ-003 nvdla_core_clk  in  1  core clock.
REQ-004 nvdla_core_rst  in  1  asynchronous active-high reset.
REQ-005 chn_lut_in_pvld/chn_lut_in_prdy  in/out  1/1  index-stream handshake.
REQ-006 chn_lut_in_pd  in  81*K  index beat, field-grouped:
- frac[35K], at [35i+34:35i]
- x[32K], base 35K
- oflow[K], base 67K
- uflow[K], base 68K
- sel[K], base 69K
- addr[9K], base 70K
- le_hit[K], base 79K
- lo_hit[K], base 80K
REQ-007 lut_rd_en  out  1  RAM read strobe, all lanes.
REQ-008 lut_rd_sel  out  K  per lane: 0=LE table, 1=LO table.
REQ-009 lut_rd_addr0/lut_rd_addr1  out  9K/9K  per-lane entry addresses.
REQ-010 lut_rd_data0/lut_rd_data1  in  16K/16K  entries; valid exactly 1 cycle after lut_rd_en.
REQ-011 chn_lut_out_pvld/chn_lut_out_prdy  out/in  1/1  result handshake.
REQ-012 chn_lut_out_pd  out  104*K  result beat, field-grouped:
- y0[16K], at [16i+15:16i]
- y1[16K], base 16K
- frac[35K], base 32K
- x[32K], base 67K
- oflow, uflow, sel, le_hit, lo_hit[K each], bases 99K..103K

Function
REQ-013 Accept a beat when chn_lut_in_pvld and chn_lut_in_prdy are both 1. Assert lut_rd_en in that same cycle.
REQ-014 chn_lut_in_prdy SHALL be 1 iff (FIFO occupancy + in-flight reads) < DEPTH. It SHALL be computed from registers only, with no combinational path from chn_lut_out_prdy.
REQ-015 lut_rd_addr0 SHALL equal addr. lut_rd_addr1 SHALL equal addr+1, clamped to the table's last index (LE: 64, LO: 256).
REQ-016 If a lane has oflow=1 or uflow=1, lut_rd_addr1 SHALL equal lut_rd_addr0. That lane's y1 SHALL equal y0.
REQ-017 The sideband fields (frac, x, flags) SHALL be registered for 1 cycle. They are then written into the FIFO together with lut_rd_data0/1 in the return cycle.
REQ-018 Latency: a beat accepted in cycle N with an empty FIFO SHALL produce chn_lut_out_pvld=1 in cycle N+2.
REQ-019 chn_lut_out_pvld SHALL equal FIFO non-empty. chn_lut_out_pd SHALL equal the FIFO head and SHALL hold stable while pvld=1 and prdy=0.
REQ-020 Pop and push in the same cycle SHALL leave occupancy unchanged.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH. Overflow SHALL be impossible by construction of REQ-014.
REQ-022 Beats SHALL leave in acceptance order. No beat is dropped or duplicated.

Reset
REQ-023 On reset: chn_lut_in_prdy=0 while reset is asserted, then 1 on the first cycle after deassertion.
REQ-024 On reset: chn_lut_out_pvld=0, lut_rd_en=0, occupancy=0, in-flight=0, pointers=0.
REQ-025 Reset mid-operation SHALL discard all in-flight and buffered beats. RAM data returning after reset SHALL be ignored.
REQ-026 Data registers need no reset. lut_rd_sel/addr0/addr1 SHALL be 0 while reset is asserted.

Structure
REQ-027 A shared package SHALL hold:
- input field base offsets, 81 per lane
- output field base offsets, 104 per lane
- LE_LAST=64, LO_LAST=256
- the per-lane field record typedefs
REQ-028 The return buffer SHALL be one sub-module, nv_nvdla_sdp_hls_y_lut_rd_fifo: a DEPTH-entry synchronous FIFO with count output.
REQ-029 Lane logic SHALL be replicated by a generate loop over K. There SHALL be no per-lane handshake.

Verification
REQ-030 Single beat: K=1, addr=5, sel=0, RAM returns 0x1234/0x1235 -> out at N+2 with y0=0x1234, y1=0x1235, frac/x unchanged.
REQ-031 Clamp: addr=64 sel=0 -> addr1=64. addr=256 sel=1 -> addr1=256. addr=63 sel=0 -> addr1=64.
REQ-032 Overflow: oflow=1, addr=256, sel=1 -> addr1=256 and y1==y0.
REQ-033 Backpressure: out_prdy=0 while feeding 6 beats -> exactly 4 accepted, in_prdy=0 after the 4th; release -> 6 beats out in order.
REQ-034 Streaming: in_pvld=1 and out_prdy=1 continuously for 100 beats -> one beat per cycle, in_prdy never drops.
REQ-035 Reset mid-stream: assert reset with 3 beats buffered -> out_pvld=0 next cycle; post-reset beat emerges alone at N+2.
